// File: rtl/hdr_parse_engine.sv
// Header parse engine: walks a configured header chain from ROOT_ID, one tag fetch per header.
// Optional packet/error counters are built in when PARSER_STATS_EN is defined.
module hdr_parse_engine #(
  parameter int HDR_NUM  = 8,
  parameter int NEXT_NUM = 2,
  parameter int ROOT_ID  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [31:0]            pkt_addr_i,
  input  logic                   cfg_we_i,
  input  logic [15:0]            cfg_hdr_id_i,
  input  logic [15:0]            cfg_hdr_len_i,
  input  logic [15:0]            cfg_tag_start_i,
  input  logic [15:0]            cfg_tag_len_i,
  input  logic [32*NEXT_NUM-1:0] cfg_next_table_i,
  output logic                   mem_ce_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [3:0]             mem_width_o,
  input  logic [31:0]            mem_data_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [HDR_NUM-1:0]     hdr_vld_o,
  input  logic [15:0]            res_id_i,
  output logic [15:0]            res_off_o,
  output logic [15:0]            parse_len_o
`ifdef PARSER_STATS_EN
  ,
  output logic [31:0]            pkt_cnt_o,
  output logic [31:0]            err_cnt_o
`endif
);

  localparam int          IW      = (HDR_NUM > 1) ? $clog2(HDR_NUM) : 1;
  localparam logic [15:0] HDR_LIM = 16'(HDR_NUM);

  // state  | meaning
  // IDLE   | ready, accepts config writes and start
  // LOOKUP | validate cur_id, record its offset
  // FETCH  | issue tag read
  // WAIT   | capture tag from memory
  // MATCH  | search next-header slots
  // DONE   | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_FETCH, S_WAIT, S_MATCH, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [15:0]           cur_id_q, cur_id_d;
  logic [15:0]           cur_off_q, cur_off_d;
  logic [31:0]           pkt_addr_q, pkt_addr_d;
  logic [HDR_NUM-1:0]    hdr_vld_q, hdr_vld_d;
  logic                  err_q, err_d;
  logic [15:0]           parse_len_q, parse_len_d;
  logic [15:0]           tag_q, tag_d;
  logic                  res_we;

  logic [15:0]           len_q    [HDR_NUM];
  logic [15:0]           tstart_q [HDR_NUM];
  logic [15:0]           tlen_q   [HDR_NUM];
  logic [32*NEXT_NUM-1:0] next_q  [HDR_NUM];
  logic [HDR_NUM-1:0]    cfg_vld_q;
  logic [15:0]           res_off_q [HDR_NUM];

  logic                  cfg_wr;
  logic [IW-1:0]         cfg_idx, cur_idx;
  logic                  id_ok;
  logic [15:0]           cur_len, cur_tstart, cur_tlen, tag_off;
  logic [32*NEXT_NUM-1:0] cur_next;
  logic [31:0]           slot;
  logic                  hit;
  logic [15:0]           hit_id;
  logic                  unused_mem;

  assign cfg_wr     = cfg_we_i && (state_q == S_IDLE) && (cfg_hdr_id_i < HDR_LIM);
  assign cfg_idx    = cfg_hdr_id_i[IW-1:0];
  assign cur_idx    = cur_id_q[IW-1:0];
  assign id_ok      = cur_id_q < HDR_LIM;
  assign cur_len    = len_q[cur_idx];
  assign cur_tstart = tstart_q[cur_idx];
  assign cur_tlen   = tlen_q[cur_idx];
  assign cur_next   = next_q[cur_idx];
  assign tag_off    = cur_off_q + cur_tstart;
  assign unused_mem = ^mem_data_i[31:16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_vld_q <= '0;
      for (int i = 0; i < HDR_NUM; i++) begin
        len_q[i]    <= '0;
        tstart_q[i] <= '0;
        tlen_q[i]   <= '0;
        next_q[i]   <= '0;
      end
    end else if (cfg_wr) begin
      cfg_vld_q[cfg_idx] <= 1'b1;
      len_q[cfg_idx]     <= cfg_hdr_len_i;
      tstart_q[cfg_idx]  <= cfg_tag_start_i;
      tlen_q[cfg_idx]    <= cfg_tag_len_i;
      next_q[cfg_idx]    <= cfg_next_table_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HDR_NUM; i++) res_off_q[i] <= '0;
    end else if (res_we) begin
      res_off_q[cur_idx] <= cur_off_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_id_q    <= '0;
      cur_off_q   <= '0;
      pkt_addr_q  <= '0;
      hdr_vld_q   <= '0;
      err_q       <= 1'b0;
      parse_len_q <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_id_q    <= cur_id_d;
      cur_off_q   <= cur_off_d;
      pkt_addr_q  <= pkt_addr_d;
      hdr_vld_q   <= hdr_vld_d;
      err_q       <= err_d;
      parse_len_q <= parse_len_d;
      tag_q       <= tag_d;
    end
  end

  // Descending scan so the lowest matching slot is the one left standing.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    slot   = '0;
    for (int s = NEXT_NUM - 1; s >= 0; s--) begin
      slot = cur_next[32*(NEXT_NUM-1-s) +: 32];
      if (slot[15:0] != 16'hFFFF && slot[31:16] == tag_q) begin
        hit    = 1'b1;
        hit_id = slot[15:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_id_d    = cur_id_q;
    cur_off_d   = cur_off_q;
    pkt_addr_d  = pkt_addr_q;
    hdr_vld_d   = hdr_vld_q;
    err_d       = err_q;
    parse_len_d = parse_len_q;
    tag_d       = tag_q;
    res_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_LOOKUP;
          cur_id_d    = 16'(ROOT_ID);
          cur_off_d   = '0;
          pkt_addr_d  = pkt_addr_i;
          hdr_vld_d   = '0;
          err_d       = 1'b0;
          parse_len_d = '0;
        end
      end
      S_LOOKUP: begin
        if (!id_ok || !cfg_vld_q[cur_idx] || hdr_vld_q[cur_idx]) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          hdr_vld_d[cur_idx] = 1'b1;
          res_we             = 1'b1;
          if (cur_tlen == 16'd0) begin
            parse_len_d = cur_off_q + cur_len;
            state_d     = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        tag_d   = (cur_tlen == 16'd1) ? {8'h00, mem_data_i[7:0]} : mem_data_i[15:0];
        state_d = S_MATCH;
      end
      S_MATCH: begin
        if (hit) begin
          cur_off_d = cur_off_q + cur_len;
          cur_id_d  = hit_id;
          state_d   = S_LOOKUP;
        end else begin
          parse_len_d = cur_off_q + cur_len;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_ce_o    = (state_q == S_FETCH);
  assign mem_we_o    = 1'b0;
  assign mem_addr_o  = mem_ce_o ? (pkt_addr_q + {16'h0000, tag_off}) : '0;
  assign mem_width_o = mem_ce_o ? cur_tlen[3:0] : '0;
  assign ready_o     = (state_q == S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
  assign hdr_vld_o   = hdr_vld_q;
  assign parse_len_o = parse_len_q;
  assign res_off_o   = (res_id_i < HDR_LIM) ? res_off_q[res_id_i[IW-1:0]] : '0;

`ifdef PARSER_STATS_EN
  logic [31:0] pkt_cnt_q, err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (state_q == S_DONE) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (err_q) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_hdr_parse_engine.sv
// Bench for hdr_parse_engine: directed scenarios plus randomized header chains against a chain-walking model.
// Also exercises the PARSER_STATS_EN counters when that macro is defined.
module tb_hdr_parse_engine;
  localparam int HDR = 8;
  localparam int NXT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] pkt_addr_i = '0;
  logic        cfg_we_i = 1'b0;
  logic [15:0] cfg_hdr_id_i = '0, cfg_hdr_len_i = '0, cfg_tag_start_i = '0, cfg_tag_len_i = '0;
  logic [63:0] cfg_next_table_i = '0;
  logic        mem_ce_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_width_o;
  logic [31:0] mem_data_i = '0;
  logic        ready_o, done_o, err_o;
  logic [HDR-1:0] hdr_vld_o;
  logic [15:0] res_id_i = '0;
  logic [15:0] res_off_o, parse_len_o;
`ifdef PARSER_STATS_EN
  logic [31:0] pkt_cnt_o, err_cnt_o;
`endif

  hdr_parse_engine #(.HDR_NUM(HDR), .NEXT_NUM(NXT), .ROOT_ID(0)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pkt_addr_i(pkt_addr_i),
    .cfg_we_i(cfg_we_i), .cfg_hdr_id_i(cfg_hdr_id_i), .cfg_hdr_len_i(cfg_hdr_len_i),
    .cfg_tag_start_i(cfg_tag_start_i), .cfg_tag_len_i(cfg_tag_len_i),
    .cfg_next_table_i(cfg_next_table_i),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_i(mem_data_i),
    .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .hdr_vld_o(hdr_vld_o),
    .res_id_i(res_id_i), .res_off_o(res_off_o), .parse_len_o(parse_len_o)
`ifdef PARSER_STATS_EN
    , .pkt_cnt_o(pkt_cnt_o), .err_cnt_o(err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference configuration and packet memory
  bit          m_cfg [HDR];
  logic [15:0] m_len [HDR], m_ts [HDR], m_tl [HDR];
  logic [15:0] m_tag [HDR][NXT], m_nid [HDR][NXT];
  logic [7:0]  mem [logic [31:0]];

  logic [HDR-1:0] exp_vld;
  logic           exp_err;
  logic [15:0]    exp_plen;
  logic [15:0]    exp_off [HDR];
  int             exp_lat;
  logic [31:0]    q_addr [$];
  logic [3:0]     q_w [$];
  int             exp_pkt = 0, exp_errc = 0;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 0, done_seen = 0;
  int cyc = 0, rd_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] mb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  task automatic set_model(input logic [15:0] id, len, ts, tl, t0, n0, t1, n1);
    if (id < 16'(HDR)) begin
      m_cfg[id] = 1'b1; m_len[id] = len; m_ts[id] = ts; m_tl[id] = tl;
      m_tag[id][0] = t0; m_nid[id][0] = n0; m_tag[id][1] = t1; m_nid[id][1] = n1;
    end
  endtask

  task automatic cfg_write(input logic [15:0] id, len, ts, tl, t0, n0, t1, n1);
    @(negedge clk);
    cfg_we_i = 1'b1; cfg_hdr_id_i = id; cfg_hdr_len_i = len;
    cfg_tag_start_i = ts; cfg_tag_len_i = tl; cfg_next_table_i = {t0, n0, t1, n1};
    @(posedge clk); #1 cfg_we_i = 1'b0;
    set_model(id, len, ts, tl, t0, n0, t1, n1);
  endtask

  // When generating, bias unseen tag bytes toward one of the entry's slot tags.
  task automatic fill_tag(input int id, input logic [31:0] a);
    logic [15:0] v;
    int s;
    v = 16'($urandom);
    s = $urandom_range(0, NXT - 1);
    if ($urandom_range(0, 3) != 0 && m_nid[id][s] != 16'hFFFF) v = m_tag[id][s];
    if (m_tl[id] == 16'd1) begin
      if (!mem.exists(a)) mem[a] = v[7:0];
    end else begin
      if (!mem.exists(a)) mem[a] = v[15:8];
      if (!mem.exists(a + 32'd1)) mem[a + 32'd1] = v[7:0];
    end
  endtask

  // Walks the header chain directly from the configuration table.
  task automatic model_parse(input logic [31:0] pa, input bit gen);
    int id, nid;
    logic [15:0] off, tag;
    logic [31:0] a;
    bit hit;
    exp_vld = '0; exp_err = 1'b0; exp_plen = '0; exp_lat = 1;
    q_addr.delete(); q_w.delete();
    id = 0; off = '0;
    for (int step = 0; step <= HDR; step++) begin
      if (id >= HDR || !m_cfg[id] || exp_vld[id]) begin
        exp_err = 1'b1; exp_lat += 1; break;
      end
      exp_vld[id] = 1'b1;
      exp_off[id] = off;
      if (m_tl[id] == 16'd0) begin
        exp_plen = off + m_len[id]; exp_lat += 1; break;
      end
      exp_lat += 4;
      a = pa + {16'h0000, 16'(off + m_ts[id])};
      q_addr.push_back(a);
      q_w.push_back(m_tl[id][3:0]);
      if (gen) fill_tag(id, a);
      tag = (m_tl[id] == 16'd1) ? {8'h00, mb(a)} : {mb(a), mb(a + 32'd1)};
      hit = 0; nid = 0;
      for (int s = 0; s < NXT; s++)
        if (!hit && m_nid[id][s] != 16'hFFFF && m_tag[id][s] == tag) begin
          hit = 1; nid = int'(m_nid[id][s]);
        end
      if (!hit) begin
        exp_plen = off + m_len[id]; break;
      end
      off = off + m_len[id];
      id = nid;
    end
  endtask

  // Memory: data for a request appears during the following cycle only.
  logic [31:0] pend = '0;
  bit          pend_v = 0;
  always @(negedge clk) begin
    mem_data_i = pend_v ? pend : $urandom;
    pend_v = mem_ce_o;
    if (mem_width_o == 4'd1) pend = {24'h0, mb(mem_addr_o)};
    else pend = {16'h0, mb(mem_addr_o), mb(mem_addr_o + 32'd1)};
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      chk("ready_busy", 64'(ready_o), 64'(0));
      chk("mem_we", 64'(mem_we_o), 64'(0));
      if (mem_ce_o) begin
        rd_cnt++;
        if (q_addr.size() == 0) begin
          n_chk++;
          $display("FAIL extra_read: got read addr 0x%0h, required no read", mem_addr_o);
        end else begin
          chk("mem_addr", 64'(mem_addr_o), 64'(q_addr.pop_front()));
          chk("mem_width", 64'(mem_width_o), 64'(q_w.pop_front()));
        end
      end
      if (done_o) begin
        chk("err", 64'(err_o), 64'(exp_err));
        chk("hdr_vld", 64'(hdr_vld_o), 64'(exp_vld));
        if (!exp_err) chk("parse_len", 64'(parse_len_o), 64'(exp_plen));
        chk("latency", 64'(cyc), 64'(exp_lat));
        chk("reads_left", 64'(q_addr.size()), 64'(0));
        done_seen = 1;
        chk_en = 0;
      end
    end
  end

  task automatic run_parse(input logic [31:0] pa, input bit gen, input bit cfg_same);
    model_parse(pa, gen);
    @(negedge clk);
    chk("ready_idle", 64'(ready_o), 64'(1));
    chk("mem_idle", 64'({mem_ce_o, mem_addr_o, mem_width_o}), 64'(0));
    start_i = 1'b1; pkt_addr_i = pa;
    if (cfg_same) cfg_we_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; cfg_we_i = 1'b0;
    cyc = 0; rd_cnt = 0; done_seen = 0; chk_en = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (done_seen) break;
    end
    if (!done_seen) begin
      n_chk++;
      $display("FAIL done_timeout: got no done_o in 400 cycles, required done_o");
      chk_en = 0;
    end
    exp_pkt++;
    if (exp_err) exp_errc++;
    @(negedge clk);
    chk("done_pulse", 64'(done_o), 64'(0));
    for (int i = 0; i < HDR; i++)
      if (exp_vld[i]) begin
        res_id_i = 16'(i); #1;
        chk("res_off", 64'(res_off_o), 64'(exp_off[i]));
      end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, 64'(ready_o), 64'(1));
    chk({tag, "_done"}, 64'(done_o), 64'(0));
    chk({tag, "_err"}, 64'(err_o), 64'(0));
    chk({tag, "_vld"}, 64'(hdr_vld_o), 64'(0));
    chk({tag, "_plen"}, 64'(parse_len_o), 64'(0));
    chk({tag, "_mem"}, 64'({mem_ce_o, mem_we_o, mem_addr_o, mem_width_o}), 64'(0));
`ifdef PARSER_STATS_EN
    chk({tag, "_cnt"}, 64'({pkt_cnt_o, err_cnt_o}), 64'(0));
`endif
  endtask

  task automatic clear_model();
    for (int i = 0; i < HDR; i++) m_cfg[i] = 0;
    exp_pkt = 0; exp_errc = 0;
    q_addr.delete(); q_w.delete();
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(negedge clk); rst = 1'b1; #1;
    reset_checks("rst");
    @(negedge clk); rst = 1'b0;
    clear_model();
  endtask

  task automatic cfg_019();
    cfg_write(16'd0, 16'd14, 16'd12, 16'd2, 16'h0800, 16'h0001, 16'hFFFF, 16'hFFFF);
    cfg_write(16'd1, 16'd20, 16'd9, 16'd1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
  endtask

  task automatic rand_cfg();
    for (int k = 0; k < 6; k++) begin
      logic [15:0] id, len, ts, tl, t0, n0, t1, n1;
      int r0, r1;
      id  = (k == 0) ? 16'd0 : 16'($urandom_range(0, 9));
      len = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'hFF00, 16'hFFFF))
                                        : 16'($urandom_range(1, 40));
      ts  = 16'($urandom_range(0, 30));
      tl  = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 2));
      t0  = (tl == 16'd1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      t1  = (tl == 16'd1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      r0  = $urandom_range(0, 11);
      r1  = $urandom_range(0, 11);
      n0  = (r0 >= 10) ? 16'hFFFF : 16'(r0);
      n1  = (r1 >= 10) ? 16'hFFFF : 16'(r1);
      cfg_write(id, len, ts, tl, t0, n0, t1, n1);
    end
  endtask

  initial begin
    bit saw;
    clear_model();
    #12;
    reset_checks("init");
    @(negedge clk); rst = 1'b0;

    // Two-header chain: 0800 selects entry 1.
    mem[32'd16] = 8'h08; mem[32'd17] = 8'h00; mem[32'd27] = 8'h06;
    cfg_019();
    model_parse(32'd4, 0);
    chk("model_rd0_addr", 64'(q_addr[0]), 64'(16));
    chk("model_rd0_w", 64'(q_w[0]), 64'(2));
    chk("model_rd1_addr", 64'(q_addr[1]), 64'(27));
    chk("model_rd1_w", 64'(q_w[1]), 64'(1));
    chk("model_lat", 64'(exp_lat), 64'(9));
    run_parse(32'd4, 0, 0);
    chk("r19_vld", 64'(hdr_vld_o), 64'(8'h03));
    chk("r19_plen", 64'(parse_len_o), 64'(34));
    chk("r19_err", 64'(err_o), 64'(0));
    chk("r19_reads", 64'(rd_cnt), 64'(2));
    res_id_i = 16'd1; #1;
    chk("r19_off1", 64'(res_off_o), 64'(14));

    // Self loop on entry 0.
    cfg_write(16'd0, 16'd14, 16'd12, 16'd2, 16'h0800, 16'h0000, 16'hFFFF, 16'hFFFF);
    run_parse(32'd4, 0, 0);
    chk("r21_err", 64'(err_o), 64'(1));
    chk("r21_vld", 64'(hdr_vld_o), 64'(8'h01));
`ifdef PARSER_STATS_EN
    chk("r24_pkt", 64'(pkt_cnt_o), 64'(2));
    chk("r24_err", 64'(err_cnt_o), 64'(1));
`endif

    // Unmatched tag ends after the root header.
    cfg_019();
    mem[32'd16] = 8'h86; mem[32'd17] = 8'hDD;
    run_parse(32'd4, 0, 0);
    chk("r20_vld", 64'(hdr_vld_o), 64'(8'h01));
    chk("r20_plen", 64'(parse_len_o), 64'(14));
    chk("r20_reads", 64'(rd_cnt), 64'(1));

    // Next id 5 unconfigured; a config write mid-parse must be dropped.
    mem[32'd16] = 8'h08; mem[32'd17] = 8'h00;
    cfg_write(16'd0, 16'd14, 16'd12, 16'd2, 16'h0800, 16'h0005, 16'hFFFF, 16'hFFFF);
    fork
      run_parse(32'd4, 0, 0);
      begin
        repeat (3) @(negedge clk);
        cfg_we_i = 1'b1; cfg_hdr_id_i = 16'd5; cfg_hdr_len_i = 16'd7;
        cfg_tag_start_i = 16'd0; cfg_tag_len_i = 16'd0; cfg_next_table_i = '1;
        @(posedge clk); #1 cfg_we_i = 1'b0;
      end
    join
    chk("r22_err", 64'(err_o), 64'(1));
    chk("r22_vld5", 64'(hdr_vld_o[5]), 64'(0));
    run_parse(32'd4, 0, 0);
    chk("r22_again_vld", 64'(hdr_vld_o), 64'(8'h01));

    // Write and start in the same cycle: parse sees the new entry.
    cfg_hdr_id_i = 16'd0; cfg_hdr_len_i = 16'd9; cfg_tag_start_i = 16'd0;
    cfg_tag_len_i = 16'd0; cfg_next_table_i = '1;
    set_model(16'd0, 16'd9, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_parse(32'd100, 0, 1);
    chk("r08_plen", 64'(parse_len_o), 64'(9));
    chk("r08_vld", 64'(hdr_vld_o), 64'(8'h01));

    // Reset while waiting for tag data, then parse with nothing configured.
    cfg_019();
    @(negedge clk); start_i = 1'b1; pkt_addr_i = 32'd4;
    @(posedge clk); #1 start_i = 1'b0;
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_ce_o) begin saw = 1; break; end
    end
    chk("r23_fetch_seen", 64'(saw), 64'(1));
    @(negedge clk); #2 rst = 1'b1; #1;
    reset_checks("r23");
    @(negedge clk); rst = 1'b0;
    clear_model();
    run_parse(32'd4, 0, 0);
    chk("r23_noconf_err", 64'(err_o), 64'(1));
    chk("r23_noconf_vld", 64'(hdr_vld_o), 64'(0));

    // Randomized chains, with periodic reset and reconfiguration.
    for (int p = 0; p < 200; p++) begin
      if (p % 50 == 0) do_reset();
      if (p % 10 == 0) rand_cfg();
      mem.delete();
      run_parse($urandom, 1, 0);
    end
`ifdef PARSER_STATS_EN
    chk("stats_pkt", 64'(pkt_cnt_o), 64'(exp_pkt));
    chk("stats_err", 64'(err_cnt_o), 64'(exp_errc));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
